// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter, SD controller and CPU bus.
package ram_arb_pkg;

  localparam int RAM_ARB_NUM_PORTS = 3;
  localparam int RAM_ARB_ADDR_W    = 32;
  localparam int RAM_ARB_DATA_W    = 32;
  localparam int RAM_ARB_MAX_PORTS = 8;
  localparam int PORT_IDX_W        = $clog2(RAM_ARB_MAX_PORTS);

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: the first asserted request after the pointer wins.
module rr_picker
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = RAM_ARB_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_idx_t            i_ptr,
  output logic                 o_valid,
  output port_idx_t            o_winner
);

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    idx      = 0;
    o_valid  = 1'b0;
    o_winner = '0;
    // Walk from the farthest candidate to the nearest so the nearest asserted request overwrites.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(i_ptr) + k) % NUM_PORTS;
      if (|(i_req & (NUM_PORTS'(1) << idx))) begin
        o_valid  = 1'b1;
        o_winner = port_idx_t'(idx);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_PORTS clients, one transaction in flight.
// Optional burst lock for SD block DMA is enabled by defining RAM_PORT_ARB_LOCK_EN.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_PORTS = RAM_ARB_NUM_PORTS,
  parameter int ADDR_W    = RAM_ARB_ADDR_W,
  parameter int DATA_W    = RAM_ARB_DATA_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             cl_req,
  input  logic [NUM_PORTS-1:0]             cl_we,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] cl_addr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] cl_wdata,
  input  logic [NUM_PORTS-1:0]             cl_lock,
  output logic [NUM_PORTS-1:0]             cl_ack,
  output logic [DATA_W-1:0]                cl_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [DATA_W-1:0]                mem_wdata,
  input  logic                             mem_ack,
  input  logic [DATA_W-1:0]                mem_rdata
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  arb_state_e r_state, w_state_next;
  port_idx_t  r_grant, w_grant_next;
  port_idx_t  r_rr, w_rr_next;
  logic       r_locked, w_locked_next;

  logic                 w_mem_req_next, w_mem_we_next;
  logic [ADDR_W-1:0]    w_mem_addr_next;
  logic [DATA_W-1:0]    w_mem_wdata_next, w_cl_rdata_next;
  logic [NUM_PORTS-1:0] w_cl_ack_next;

  logic             w_pick_valid;
  port_idx_t        w_pick;
  port_idx_t        w_sel;
  logic [IDX_W-1:0] w_gidx, w_sel_idx;
  logic             w_use_lock, w_lock_beat;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_picker (
    .i_req    (cl_req),
    .i_ptr    (r_rr),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick)
  );

  assign w_gidx = r_grant[IDX_W-1:0];

`ifdef RAM_PORT_ARB_LOCK_EN
  // A locked port keeps the grant only while it still requests.
  assign w_use_lock  = r_locked & cl_req[w_gidx];
  assign w_lock_beat = cl_lock[w_gidx];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^cl_lock;
  assign w_use_lock    = 1'b0;
  assign w_lock_beat   = 1'b0;
`endif

  assign w_sel     = w_use_lock ? r_grant : w_pick;
  assign w_sel_idx = w_sel[IDX_W-1:0];

  always_comb begin
    w_state_next     = r_state;
    w_grant_next     = r_grant;
    w_rr_next        = r_rr;
    w_locked_next    = r_locked;
    w_mem_req_next   = mem_req;
    w_mem_we_next    = mem_we;
    w_mem_addr_next  = mem_addr;
    w_mem_wdata_next = mem_wdata;
    w_cl_rdata_next  = cl_rdata;
    w_cl_ack_next    = '0;
    unique case (r_state)
      IDLE: begin
        w_mem_req_next = 1'b0;
        if (w_use_lock || w_pick_valid) begin
          w_mem_req_next   = 1'b1;
          w_mem_we_next    = cl_we[w_sel_idx];
          w_mem_addr_next  = cl_addr[w_sel_idx];
          w_mem_wdata_next = cl_wdata[w_sel_idx];
          w_grant_next     = w_sel;
          w_locked_next    = 1'b0;
          w_state_next     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          w_mem_req_next = 1'b0;
          if (!mem_we) w_cl_rdata_next = mem_rdata;
          w_cl_ack_next = NUM_PORTS'(1) << r_grant;
          // Locked beats leave the pointer where it was so the burst does not steal a turn.
          if (w_lock_beat) w_locked_next = 1'b1;
          else             w_rr_next     = r_grant;
          w_state_next = RESP;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr      <= port_idx_t'(NUM_PORTS - 1);
      r_locked  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cl_ack    <= '0;
      cl_rdata  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_grant   <= w_grant_next;
      r_rr      <= w_rr_next;
      r_locked  <= w_locked_next;
      mem_req   <= w_mem_req_next;
      mem_we    <= w_mem_we_next;
      mem_addr  <= w_mem_addr_next;
      mem_wdata <= w_mem_wdata_next;
      cl_ack    <= w_cl_ack_next;
      cl_rdata  <= w_cl_rdata_next;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter; expectations follow the build's RAM_PORT_ARB_LOCK_EN setting.
module tb_ram_port_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        cl_req, cl_we, cl_lock, cl_ack;
  logic [2:0][31:0]  cl_addr, cl_wdata;
  logic [31:0]       cl_rdata;
  logic              mem_req, mem_we, mem_ack;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cl_req    (cl_req),
    .cl_we     (cl_we),
    .cl_addr   (cl_addr),
    .cl_wdata  (cl_wdata),
    .cl_lock   (cl_lock),
    .cl_ack    (cl_ack),
    .cl_rdata  (cl_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   64'(mem_req),   64'd0);
    check({tag, "_mem_we"},    64'(mem_we),    64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cl_ack"},    64'(cl_ack),    64'd0);
    check({tag, "_cl_rdata"},  64'(cl_rdata),  64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cl_req = '0; cl_we = '0; cl_lock = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    exp_rdata = 32'h0;
    reset = 1'b0;
  endtask

  // Waits for mem_req, checks latency and forwarded fields, returns mem_ack, checks the client ack.
  task automatic serve(input string tag, input logic [1:0] port, input int exp_wait,
                       input int ack_delay, input logic [31:0] rd);
    int waited;
    logic [2:0] exp_ack;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!mem_req && waited < 20);
    if (!mem_req) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_lat"},  64'(waited),   64'(exp_wait));
    check({tag, "_addr"}, 64'(mem_addr), 64'(cl_addr[port]));
    check({tag, "_we"},   64'(mem_we),   64'(cl_we[port]));
    if (cl_we[port]) check({tag, "_wdata"}, 64'(mem_wdata), 64'(cl_wdata[port]));
    repeat (ack_delay) begin
      @(negedge clk);
      check({tag, "_hold"}, {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, cl_addr[port]});
      check({tag, "_early_ack"}, 64'(cl_ack), 64'd0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    if (!cl_we[port]) exp_rdata = rd;
    exp_ack = 3'b001 << port;
    check({tag, "_ack"},     64'(cl_ack),   64'(exp_ack));
    check({tag, "_rdata"},   64'(cl_rdata), 64'(exp_rdata));
    check({tag, "_req_off"}, 64'(mem_req),  64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] lock_order [5];
    cl_addr = '0; cl_wdata = '0; mem_rdata = '0;
    do_reset();

    // Single read on port 1 with one wait cycle before mem_ack.
    cl_addr[1] = 32'h100;
    cl_req[1]  = 1'b1;
    serve("rd1", 2'd1, 1, 1, 32'hDEAD_BEEF);
    cl_req = '0;
    @(negedge clk);
    check("rd1_ack_pulse", 64'(cl_ack), 64'd0);

    // All three ports request continuously: order 0,1,2,0,1,2.
    do_reset();
    cl_addr[0] = 32'h1000; cl_addr[1] = 32'h2000; cl_addr[2] = 32'h3000;
    cl_req = 3'b111;
    for (int k = 0; k < 6; k++)
      serve($sformatf("rr%0d", k), 2'(k % 3), (k == 0) ? 1 : 2, 0, 32'h1000_0000 + 32'(k));
    cl_req = '0;
    @(negedge clk);

    // Write on port 2: cl_rdata must keep the last read value.
    cl_we[2] = 1'b1; cl_addr[2] = 32'h40; cl_wdata[2] = 32'h1234_5678;
    cl_req[2] = 1'b1;
    serve("wr", 2'd2, 1, 0, 32'hFFFF_0000);
    cl_req = '0;
    @(negedge clk);
    cl_we = '0;

    // Spurious mem_ack while idle is ignored and the arbiter stays IDLE.
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spur_ack",   64'(cl_ack),   64'd0);
    check("spur_req",   64'(mem_req),  64'd0);
    check("spur_rdata", 64'(cl_rdata), 64'(exp_rdata));
    cl_addr[0] = 32'h1000;
    cl_req[0] = 1'b1;
    serve("spur_next", 2'd0, 1, 0, 32'h0000_0011);
    cl_req = '0;
    @(negedge clk);

    // Reset while BUSY abandons the transaction; afterwards port 0 wins first.
    cl_addr[1] = 32'h2000;
    cl_req[1] = 1'b1;
    @(negedge clk);
    check("busy_req", 64'(mem_req), 64'd1);
    reset = 1'b1; cl_req = '0; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    check_reset_outputs("busy_rst");
    exp_rdata = 32'h0;
    reset = 1'b0;
    cl_req = 3'b111;
    serve("post_rst", 2'd0, 1, 0, 32'h0000_0022);
    cl_req = '0;
    @(negedge clk);

    // Port 2 starts alone with lock, then ports 0/1 join; lock drops on the 4th beat.
`ifdef RAM_PORT_ARB_LOCK_EN
    lock_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
`else
    lock_order = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
`endif
    cl_req = 3'b100;
    for (int b = 0; b < 5; b++) begin
      cl_lock[2] = (b < 3);
      serve($sformatf("lock%0d", b), lock_order[b], (b == 0) ? 1 : 2, 0, 32'h2000_0000 + 32'(b));
      cl_req = 3'b111;
    end
    cl_req = '0; cl_lock = '0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
